// File: rtl/williams_sc1_pkg.sv
// Shared definitions for the SC1 blitter: register map, control bits, FSM states.
// Build option WILLIAMS_SC1_XOR4_EN reproduces the silicon XOR-4 bug on width/height.
package williams_sc1_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SOLID  = 3'd1;
  localparam logic [2:0] REG_SRC_HI = 3'd2;
  localparam logic [2:0] REG_SRC_LO = 3'd3;
  localparam logic [2:0] REG_DST_HI = 3'd4;
  localparam logic [2:0] REG_DST_LO = 3'd5;
  localparam logic [2:0] REG_WIDTH  = 3'd6;
  localparam logic [2:0] REG_HEIGHT = 3'd7;

  localparam int CB_SRC_STRIDE = 0;
  localparam int CB_DST_STRIDE = 1;
  localparam int CB_SLOW       = 2;
  localparam int CB_FG_ONLY    = 3;
  localparam int CB_SOLID      = 4;
  localparam int CB_SHIFT      = 5;
  localparam int CB_NO_EVEN    = 6;
  localparam int CB_NO_ODD     = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_HALT,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Programmed dimension to byte count; a value of zero means 256.
  function automatic logic [8:0] eff_dim(input logic [7:0] v);
    logic [7:0] t;
`ifdef WILLIAMS_SC1_XOR4_EN
    t = v ^ 8'h04;
`else
    t = v;
`endif
    eff_dim = {(t == 8'h00), t};
  endfunction

endpackage

// File: rtl/williams_sc1_datapath.sv
// Per-byte data path: nibble shift, solid colour substitution and nibble write enables.
module williams_sc1_datapath
  import williams_sc1_pkg::*;
(
  input  logic [7:0] ctrl,
  input  logic [7:0] solid,
  input  logic [7:0] rd_data,
  input  logic [3:0] prev_nib,
  output logic [7:0] wr_data,
  output logic [1:0] nib_en
);

  logic [7:0] s;

  always_comb begin
    s       = ctrl[CB_SHIFT] ? {prev_nib, rd_data[7:4]} : rd_data;
    wr_data = ctrl[CB_SOLID] ? solid : s;
    nib_en  = 2'b11;
    // Transparency looks at the source pixels even when painting solid colour.
    if (ctrl[CB_FG_ONLY]) begin
      if (s[7:4] == 4'h0) nib_en[1] = 1'b0;
      if (s[3:0] == 4'h0) nib_en[0] = 1'b0;
    end
    if (ctrl[CB_NO_EVEN]) nib_en[1] = 1'b0;
    if (ctrl[CB_NO_ODD])  nib_en[0] = 1'b0;
  end

endmodule

// File: rtl/williams_sc1.sv
// Williams SC1 blitter top: register file, halt/read/write sequencer and address stepping.
// Define WILLIAMS_SC1_XOR4_EN to XOR width and height with 4 like the original SC1 part.
module williams_sc1
  import williams_sc1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_e_n,
  input  logic        reg_cs,
  input  logic [7:0]  reg_data_in,
  input  logic [2:0]  rs,
  output logic        halt,
  input  logic        halt_ack,
  input  logic        blt_ack,
  output logic        blt_rd,
  output logic        blt_wr,
  output logic [15:0] blt_address_out,
  input  logic [7:0]  blt_data_in,
  output logic [7:0]  blt_data_out,
  output logic [1:0]  blt_nibble_en
);

  state_t      state, state_nx;
  logic [7:0]  ctrl_r, solid_r, src_hi_r, src_lo_r, dst_hi_r, dst_lo_r, width_r, height_r;
  logic [15:0] src_cur, dst_cur, src_row, dst_row;
  logic [15:0] src_row_nx, dst_row_nx;
  logic [15:0] src_byte_step, dst_byte_step, src_row_step, dst_row_step;
  logic [8:0]  eff_w, eff_h, x_cnt, y_cnt;
  logic [7:0]  rd_data;
  logic [3:0]  prev_nib;
  logic        req, req_go, acked, last_col, last_row, start;
  logic [7:0]  dp_data;
  logic [1:0]  dp_en;

  assign eff_w    = eff_dim(width_r);
  assign eff_h    = eff_dim(height_r);
  assign start    = (state == ST_IDLE) && reg_cs && (rs == REG_CTRL);
  assign req_go   = !req && halt_ack && (!ctrl_r[CB_SLOW] || en_e_n);
  assign acked    = req && blt_ack;
  assign last_col = (x_cnt == 9'd1);
  assign last_row = (y_cnt == 9'd1);

  assign src_byte_step = ctrl_r[CB_SRC_STRIDE] ? 16'h0100 : 16'h0001;
  assign dst_byte_step = ctrl_r[CB_DST_STRIDE] ? 16'h0100 : 16'h0001;
  assign src_row_step  = ctrl_r[CB_SRC_STRIDE] ? 16'h0001 : {7'd0, eff_w};
  assign dst_row_step  = ctrl_r[CB_DST_STRIDE] ? 16'h0001 : {7'd0, eff_w};
  assign src_row_nx    = src_row + src_row_step;
  assign dst_row_nx    = dst_row + dst_row_step;

  // Register file is only writable while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_r   <= '0;
      solid_r  <= '0;
      src_hi_r <= '0;
      src_lo_r <= '0;
      dst_hi_r <= '0;
      dst_lo_r <= '0;
      width_r  <= '0;
      height_r <= '0;
    end else if (state == ST_IDLE && reg_cs) begin
      case (rs)
        REG_CTRL:   ctrl_r   <= reg_data_in;
        REG_SOLID:  solid_r  <= reg_data_in;
        REG_SRC_HI: src_hi_r <= reg_data_in;
        REG_SRC_LO: src_lo_r <= reg_data_in;
        REG_DST_HI: dst_hi_r <= reg_data_in;
        REG_DST_LO: dst_lo_r <= reg_data_in;
        REG_WIDTH:  width_r  <= reg_data_in;
        default:    height_r <= reg_data_in;
      endcase
    end
  end

  // Working copies of the addresses, so the programmed registers stay untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req      <= 1'b0;
      src_cur  <= '0;
      dst_cur  <= '0;
      src_row  <= '0;
      dst_row  <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      rd_data  <= '0;
      prev_nib <= '0;
    end else begin
      case (state)
        ST_REQ_HALT: begin
          req      <= 1'b0;
          src_cur  <= {src_hi_r, src_lo_r};
          src_row  <= {src_hi_r, src_lo_r};
          dst_cur  <= {dst_hi_r, dst_lo_r};
          dst_row  <= {dst_hi_r, dst_lo_r};
          x_cnt    <= eff_w;
          y_cnt    <= eff_h;
          prev_nib <= 4'h0;
        end
        ST_READ: begin
          if (acked) begin
            req     <= 1'b0;
            rd_data <= blt_data_in;
          end else if (req_go) begin
            req <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (acked) begin
            req <= 1'b0;
            if (last_col) begin
              x_cnt    <= eff_w;
              y_cnt    <= y_cnt - 9'd1;
              src_row  <= src_row_nx;
              src_cur  <= src_row_nx;
              dst_row  <= dst_row_nx;
              dst_cur  <= dst_row_nx;
              prev_nib <= 4'h0;
            end else begin
              x_cnt    <= x_cnt - 9'd1;
              src_cur  <= src_cur + src_byte_step;
              dst_cur  <= dst_cur + dst_byte_step;
              prev_nib <= rd_data[3:0];
            end
          end else if (req_go) begin
            req <= 1'b1;
          end
        end
        default: req <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_REQ_HALT;
      ST_REQ_HALT: if (halt_ack) state_nx = ST_READ;
      ST_READ:     if (acked) state_nx = ST_WRITE;
      ST_WRITE:    if (acked) state_nx = (last_col && last_row) ? ST_DONE : ST_READ;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    halt            = (state == ST_REQ_HALT) || (state == ST_READ) || (state == ST_WRITE);
    blt_rd          = (state == ST_READ) && req;
    blt_wr          = (state == ST_WRITE) && req;
    blt_address_out = 16'h0000;
    blt_data_out    = 8'h00;
    blt_nibble_en   = 2'b00;
    if (state == ST_READ) begin
      blt_address_out = src_cur;
    end else if (state == ST_WRITE) begin
      blt_address_out = dst_cur;
      blt_data_out    = dp_data;
      blt_nibble_en   = dp_en;
    end
  end

  williams_sc1_datapath u_dp (
    .ctrl     (ctrl_r),
    .solid    (solid_r),
    .rd_data  (rd_data),
    .prev_nib (prev_nib),
    .wr_data  (dp_data),
    .nib_en   (dp_en)
  );

endmodule

// File: tb/tb_williams_sc1.sv
// Directed bench for williams_sc1: bus responder with access logs plus hand-computed vectors.
`timescale 1ns/1ps
module tb_williams_sc1;

`ifdef WILLIAMS_SC1_XOR4_EN
  localparam logic [7:0] DIM1 = 8'h05, DIM2 = 8'h06, DIM256 = 8'h04;
  localparam int BASIC_N = 16;
`else
  localparam logic [7:0] DIM1 = 8'h01, DIM2 = 8'h02, DIM256 = 8'h00;
  localparam int BASIC_N = 20;
`endif

  logic        clk = 1'b0, rst = 1'b0, en_e_n = 1'b0, reg_cs = 1'b0;
  logic [7:0]  reg_data_in = 8'h00;
  logic [2:0]  rs = 3'd0;
  logic        halt, halt_ack = 1'b0, blt_ack = 1'b0, blt_rd, blt_wr;
  logic [15:0] blt_address_out;
  logic [7:0]  blt_data_in = 8'h00, blt_data_out;
  logic [1:0]  blt_nibble_en;

  williams_sc1 dut (
    .clk(clk), .rst(rst), .en_e_n(en_e_n), .reg_cs(reg_cs), .reg_data_in(reg_data_in),
    .rs(rs), .halt(halt), .halt_ack(halt_ack), .blt_ack(blt_ack), .blt_rd(blt_rd),
    .blt_wr(blt_wr), .blt_address_out(blt_address_out), .blt_data_in(blt_data_in),
    .blt_data_out(blt_data_out), .blt_nibble_en(blt_nibble_en)
  );

  always #42 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Knobs written only by the stimulus process.
  int         rd_mode = 0, seq_base = 0;
  logic [7:0] rd_const = 8'h00;
  logic [7:0] rd_seq [4];
  bit         wr_ack_en = 1'b1, ha_block = 1'b0, slow_chk = 1'b0;

  // Logs written only by the responder.
  logic [15:0] rd_a [2048];
  logic [15:0] wr_a [2048];
  logic [7:0]  wr_d [2048];
  logic [1:0]  wr_e [2048];
  int rd_n = 0, wr_n = 0, n_ack = 0, rises = 0, viol = 0, cyc = 0, ecnt = 0;
  int last_wr_ack_cyc = -1, halt_fall_cyc = -2;
  bit ack_wr = 1'b0, halt_q = 1'b0, req_q = 1'b0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (halt_q && !halt) halt_fall_cyc = cyc;
    halt_q = halt;
    if (blt_ack) begin
      if (ack_wr) last_wr_ack_cyc = cyc;
      blt_ack = 1'b0;
    end else if (blt_rd) begin
      rd_a[rd_n] = blt_address_out;
      case (rd_mode)
        0:       blt_data_in = pat(blt_address_out);
        1:       blt_data_in = rd_const;
        default: blt_data_in = rd_seq[2'((rd_n - seq_base) & 3)];
      endcase
      rd_n = rd_n + 1;
      blt_ack = 1'b1; ack_wr = 1'b0; n_ack = n_ack + 1;
    end else if (blt_wr && wr_ack_en) begin
      wr_a[wr_n] = blt_address_out;
      wr_d[wr_n] = blt_data_out;
      wr_e[wr_n] = blt_nibble_en;
      wr_n = wr_n + 1;
      blt_ack = 1'b1; ack_wr = 1'b1; n_ack = n_ack + 1;
    end
    if (slow_chk && (blt_rd || blt_wr) && !req_q) begin
      rises = rises + 1;
      if (!en_e_n) viol = viol + 1;
    end
    req_q = blt_rd || blt_wr;
    ecnt = ecnt + 1;
    en_e_n = ((ecnt % 5) == 0);
    halt_ack = halt && !ha_block;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; rs = a; reg_data_in = d;
    @(negedge clk);
    reg_cs = 1'b0;
  endtask

  task automatic start_blit(input logic [7:0] ctrl, input logic [7:0] solid, input logic [15:0] src,
                            input logic [15:0] dst, input logic [7:0] w, input logic [7:0] h);
    wr_reg(3'd1, solid);
    wr_reg(3'd2, src[15:8]);
    wr_reg(3'd3, src[7:0]);
    wr_reg(3'd4, dst[15:8]);
    wr_reg(3'd5, dst[7:0]);
    wr_reg(3'd6, w);
    wr_reg(3'd7, h);
    wr_reg(3'd0, ctrl);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!halt) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    check_val({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int rb, wb, ab, n, ea, ew, ed, ee;
    rd_seq[0] = 8'h12; rd_seq[1] = 8'h34; rd_seq[2] = 8'h56; rd_seq[3] = 8'h78;

    repeat (3) @(negedge clk);
    check_val("rst_halt", 32'(halt), 32'd0);
    check_val("rst_rdwr", 32'({blt_rd, blt_wr}), 32'd0);
    check_val("rst_addr", 32'(blt_address_out), 32'd0);
    check_val("rst_data", 32'({blt_data_out, 6'd0, blt_nibble_en}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic contiguous copy
    rb = rd_n; wb = wr_n; ab = n_ack; n = BASIC_N * BASIC_N; rd_mode = 0;
    start_blit(8'h00, 8'h3c, 16'hFCF5, 16'h0000, 8'h14, 8'h14);
    check_val("basic_halt_rise", 32'(halt), 32'd1);
    wait_done("basic");
    check_val("basic_rd_n", 32'(rd_n - rb), 32'(n));
    check_val("basic_wr_n", 32'(wr_n - wb), 32'(n));
    check_val("basic_acks", 32'(n_ack - ab), 32'(2 * n));
    check_val("basic_rd_last", 32'(rd_a[rb + n - 1]), 32'(16'hFCF5 + 16'(n - 1)));
    check_val("basic_halt_fall", 32'(halt_fall_cyc), 32'(last_wr_ack_cyc));
    ea = 0; ew = 0; ed = 0; ee = 0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa;
      sa = 16'hFCF5 + 16'(i);
      if (rd_a[rb + i] !== sa) ea++;
      if (wr_a[wb + i] !== 16'(i)) ew++;
      if (wr_d[wb + i] !== pat(sa)) ed++;
      if (wr_e[wb + i] !== 2'b11) ee++;
    end
    check_val("basic_rd_addr_errs", 32'(ea), 32'd0);
    check_val("basic_wr_addr_errs", 32'(ew), 32'd0);
    check_val("basic_data_errs", 32'(ed), 32'd0);
    check_val("basic_en_errs", 32'(ee), 32'd0);

    // Solid colour with foreground-only transparency
    wb = wr_n; rd_mode = 1; rd_const = 8'hF0;
    start_blit(8'h18, 8'h3c, 16'h0500, 16'h0600, DIM2, DIM2);
    wait_done("solid");
    check_val("solid_wr_n", 32'(wr_n - wb), 32'd4);
    ed = 0;
    for (int i = 0; i < 4; i++)
      if (wr_d[wb + i] !== 8'h3c || wr_e[wb + i] !== 2'b10) ed++;
    check_val("solid_errs", 32'(ed), 32'd0);

    // Column stride on both sides
    rb = rd_n; wb = wr_n; rd_mode = 0;
    start_blit(8'h03, 8'h00, 16'h1000, 16'h2000, DIM2, DIM2);
    wait_done("stride");
    check_val("stride_rd1", 32'(rd_a[rb + 1]), 32'h1100);
    check_val("stride_rd2", 32'(rd_a[rb + 2]), 32'h1001);
    check_val("stride_rd3", 32'(rd_a[rb + 3]), 32'h1101);
    check_val("stride_wr1", 32'(wr_a[wb + 1]), 32'h2100);
    check_val("stride_wr3", 32'(wr_a[wb + 3]), 32'h2101);
    check_val("stride_wr3_data", 32'(wr_d[wb + 3]), 32'(pat(16'h1101)));

    // Restart with only the control register: addresses must be the programmed ones
    rb = rd_n;
    wr_reg(3'd0, 8'h03);
    wait_done("restart");
    check_val("restart_rd0", 32'(rd_a[rb]), 32'h1000);

    // Address wrap at 0xFFFF
    rb = rd_n; wb = wr_n;
    start_blit(8'h00, 8'h00, 16'hFFFF, 16'hFFFE, DIM2, DIM2);
    wait_done("wrap");
    check_val("wrap_rd1", 32'(rd_a[rb + 1]), 32'h0000);
    check_val("wrap_rd2", 32'(rd_a[rb + 2]), 32'h0001);
    check_val("wrap_wr2", 32'(wr_a[wb + 2]), 32'h0000);

    // Nibble shift with reset of the carried nibble at each row
    wb = wr_n; rd_mode = 2; seq_base = rd_n;
    start_blit(8'h20, 8'h00, 16'h0300, 16'h0400, DIM2, DIM2);
    wait_done("shift");
    check_val("shift_d0", 32'(wr_d[wb + 0]), 32'h01);
    check_val("shift_d1", 32'(wr_d[wb + 1]), 32'h23);
    check_val("shift_d2", 32'(wr_d[wb + 2]), 32'h05);
    check_val("shift_d3", 32'(wr_d[wb + 3]), 32'h67);

    // Nibble suppression; a fully suppressed write is still issued
    rd_mode = 1; rd_const = 8'hAB;
    wb = wr_n;
    start_blit(8'h40, 8'h00, 16'h0010, 16'h0020, DIM1, DIM1);
    wait_done("sup40");
    check_val("sup40_en", 32'(wr_e[wb]), 32'b01);
    check_val("sup40_data", 32'(wr_d[wb]), 32'hAB);
    wb = wr_n;
    start_blit(8'h80, 8'h00, 16'h0010, 16'h0020, DIM1, DIM1);
    wait_done("sup80");
    check_val("sup80_en", 32'(wr_e[wb]), 32'b10);
    wb = wr_n;
    start_blit(8'hC0, 8'h00, 16'h0010, 16'h0020, DIM1, DIM1);
    wait_done("supC0");
    check_val("supC0_wr_n", 32'(wr_n - wb), 32'd1);
    check_val("supC0_en", 32'(wr_e[wb]), 32'b00);

    // Width register 0 means 256 bytes
    rb = rd_n; wb = wr_n; rd_mode = 0;
    start_blit(8'h00, 8'h00, 16'h0100, 16'h8000, DIM256, DIM1);
    wait_done("w256");
    check_val("w256_rd_n", 32'(rd_n - rb), 32'd256);
    check_val("w256_rd_last", 32'(rd_a[rb + 255]), 32'h01FF);
    check_val("w256_wr_last", 32'(wr_a[wb + 255]), 32'h80FF);

    // Slow mode: every request follows an E pulse
    rb = rd_n; slow_chk = 1'b1;
    start_blit(8'h04, 8'h00, 16'h3000, 16'h4000, DIM2, DIM2);
    wait_done("slow");
    slow_chk = 1'b0;
    check_val("slow_rd_n", 32'(rd_n - rb), 32'd4);
    check_val("slow_rises", 32'(rises), 32'd8);
    check_val("slow_viol", 32'(viol), 32'd0);

    // halt_ack withheld: no access until it returns; register writes ignored while busy
    ha_block = 1'b1; rb = rd_n; wb = wr_n;
    start_blit(8'h10, 8'h3c, 16'h0700, 16'h0800, DIM1, DIM1);
    wr_reg(3'd1, 8'h99);
    repeat (20) @(negedge clk);
    check_val("hold_halt", 32'(halt), 32'd1);
    check_val("hold_no_rd", 32'(rd_n - rb), 32'd0);
    ha_block = 1'b0;
    wait_done("hold");
    check_val("hold_rd_n", 32'(rd_n - rb), 32'd1);
    check_val("hold_busy_write_ignored", 32'(wr_d[wb]), 32'h3c);

    // Reset while a write is outstanding
    wr_ack_en = 1'b0;
    start_blit(8'h00, 8'h00, 16'h0900, 16'h0A00, DIM2, DIM2);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (blt_wr) begin seen = 1'b1; break; end
      end
      check_val("rstmid_wr_seen", 32'(seen), 32'd1);
    end
    #1 rst = 1'b0;
    #1;
    check_val("rstmid_outs", 32'({halt, blt_rd, blt_wr}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1; wr_ack_en = 1'b1;
    wb = wr_n;
    start_blit(8'h00, 8'h00, 16'h0B00, 16'h0C00, DIM1, DIM1);
    wait_done("after_rst");
    check_val("after_rst_wr_n", 32'(wr_n - wb), 32'd1);
    check_val("after_rst_wr_a", 32'(wr_a[wb]), 32'h0C00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/williams_sc1.md
Name: williams_sc1

Overview:
- Williams SC1 "special chip" blitter: a memory-to-memory block copier/filler for 4-bit-per-pixel video RAM.
- The CPU programs eight byte registers. Writing the control register halts the CPU and starts a copy.
- The copy is a read/write sequence over a 16-bit bus, with nibble masking, transparency, solid fill and nibble shift.
- Sits between the 6809 bus decoder and the memory arbiter.

Parameters:
- none

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- en_e_n  in  1  E-phase marker, one clk-wide pulse per CPU cycle; used by slow mode
- reg_cs  in  1  register write strobe, one clk wide
- reg_data_in  in  8  register write data
- rs  in  3  register select
- halt  out  1  CPU halt request
- halt_ack  in  1  CPU halted (level)
- blt_ack  in  1  current bus access complete, one clk wide
- blt_rd  out  1  read request
- blt_wr  out  1  write request
- blt_address_out  out  16  access address
- blt_data_in  in  8  read data, valid when blt_ack is high during a read
- blt_data_out  out  8  write data
- blt_nibble_en  out  2  write enables; bit1 = upper (even) nibble, bit0 = lower (odd) nibble

Behaviour:
- Reset: all registers 0; state IDLE; halt, blt_rd, blt_wr = 0; address, data and nibble_en outputs = 0. Reset mid-operation aborts immediately.
- Register map, written on any clk edge with reg_cs=1 while IDLE (writes while busy are ignored):
  - 0 = control (write starts a blit)
  - 1 = solid colour
  - 2/3 = source address hi/lo
  - 4/5 = destination address hi/lo
  - 6 = width
  - 7 = height
- Control bits:
  - 0 = source column stride
  - 1 = destination column stride
  - 2 = slow
  - 3 = foreground only
  - 4 = solid
  - 5 = shift
  - 6 = suppress even (upper) nibble
  - 7 = suppress odd (lower) nibble
- Effective width/height: register value (XORed with 4 when the optional feature is enabled); an effective value of 0 means 256.
- State sequence: IDLE → REQ_HALT → READ → WRITE → (loop) → DONE → IDLE.
  - REQ_HALT: halt=1 the cycle after the control write; wait for halt_ack=1.
  - READ: blt_rd=1 with the current source address; hold until blt_ack; capture blt_data_in on the ack edge; drop blt_rd the next cycle.
  - WRITE: blt_wr=1 with the destination address, blt_data_out and blt_nibble_en; hold until blt_ack.
- Address stepping:
  - Per byte: source advances +256 if ctrl[0] else +1; destination likewise with ctrl[1].
  - Per row: row start advances +1 if the stride bit is set, else +width.
  - All arithmetic is mod 2^16 and wraps silently.
- Data path for each byte:
  - Shift: when ctrl[5]=1, s = {previous byte low nibble, current high nibble}; previous is cleared to 0 at each row start. Otherwise s = read data.
  - Output data: blt_data_out = solid colour register if ctrl[4], else s.
  - Nibble enable: blt_nibble_en starts at 2'b11. ctrl[3] clears each bit whose s nibble is 0. ctrl[6] clears bit1; ctrl[7] clears bit0.
  - A write whose nibble_en is 00 is still issued.
- Slow mode (ctrl[2]): each READ/WRITE request rises only on the cycle after en_e_n=1.
- Completion: after the final write ack, halt=0 the next cycle; registers keep their values, with addresses left at their initial programmed values.
- halt_ack dropping mid-blit: the pending request is held until halt_ack returns.

Optional Feature:
- Macro WILLIAMS_SC1_XOR4_EN.
  - Defined: width and height are XORed with 4 (SC1 silicon bug); 0x14 gives 16.
  - Undefined: values are used as written; 0x14 gives 20.

Decomposition:
- Package williams_sc1_pkg: register index constants, control bit positions, state enum.
- One sub-module, williams_sc1_datapath: combinational shift, solid and nibble-enable logic.

Test Plan (feature defined):
- Basic copy: solid 0x3c, src 0xFCF5, dst 0x0000, w=h=0x14, ctrl 0x00; ack every access.
  - halt rises, then 256 reads at FCF5..FDF4 and 256 writes at 0000..00FF with nibble_en 11.
  - 512 acks total; halt falls after the last ack.
- Solid + foreground (ctrl 0x18, solid 0x3c), read data 0xF0: every write carries 0x3c with nibble_en 10.
- Column stride (ctrl 0x03), w=h=0x05 (1×1 effective… use 0x06 for 2×2): source/destination step +256 per byte, +1 per row.
- Shift (ctrl 0x20), 2-wide row read 0x12, 0x34: writes 0x01 then 0x23; previous nibble reset at the next row.
- Suppression: ctrl 0x40 gives nibble_en 01; ctrl 0x80 gives 10; ctrl 0xC0 gives 00.
- rst=0 during the WRITE state: halt, blt_rd and blt_wr drop immediately; a new start works normally.
